// File: rtl/led_blink_ctrl.sv
// LED blink controller: prescaled continuous square wave or counted burst of blinks.
// Rate changes are applied only at half-period boundaries.
module led_blink_ctrl #(
    parameter int unsigned DIV0    = 12_500_000,
    parameter int unsigned DIV1    = 6_250_000,
    parameter int unsigned DIV2    = 2_500_000,
    parameter int unsigned DIV3    = 1_250_000,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned BURST_W = 4
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_mode,
    input  logic [1:0]         i_sel,
    input  logic               i_start,
    input  logic [BURST_W-1:0] i_count,
    output logic               o_led,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StBOn,
        StBOff
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_sel;
    logic [BURST_W-1:0] r_rem;
    logic               r_led;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_div_m1;
    logic               w_tick;

    always_comb begin
        w_div_m1 = CNT_W'(DIV0 - 1);
        case (r_sel)
            2'd0:    w_div_m1 = CNT_W'(DIV0 - 1);
            2'd1:    w_div_m1 = CNT_W'(DIV1 - 1);
            2'd2:    w_div_m1 = CNT_W'(DIV2 - 1);
            default: w_div_m1 = CNT_W'(DIV3 - 1);
        endcase
    end

    assign w_tick = (r_cnt == w_div_m1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_sel   <= 2'd0;
            r_rem   <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_led <= 1'b0;
                    r_cnt <= '0;
                    if (!i_mode) begin
                        r_state <= StRun;
                        r_sel   <= i_sel;
                        r_led   <= 1'b1;
                    end else if (i_start && (i_count != '0)) begin
                        r_state <= StBOn;
                        r_sel   <= i_sel;
                        r_rem   <= i_count;
                        r_led   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        r_sel <= i_sel;
                        // Mode is only looked at on a tick so the last phase completes
                        if (i_mode) begin
                            r_state <= StIdle;
                            r_led   <= 1'b0;
                        end else begin
                            r_led <= ~r_led;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StBOn: begin
                    if (w_tick) begin
                        r_state <= StBOff;
                        r_cnt   <= '0;
                        r_sel   <= i_sel;
                        r_led   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StBOff: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        r_sel <= i_sel;
                        if (r_rem == BURST_W'(1)) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StBOn;
                            r_rem   <= r_rem - BURST_W'(1);
                            r_led   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_led  = r_led;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
